// File: rtl/intr_csr_if.sv
// ---------------------------------------------------------------------------
// intr_csr_if -- CSR access bus between the control FSM and intr_csr.
//
// Signals
//   csr_WE    write strobe (master -> slave)
//   csr_addr  12-bit CSR address, instruction bits [31:20] (master -> slave)
//   csr_wd    32-bit write data, already merged for rw/rs/rc (master -> slave)
//   csr_rd    32-bit combinational read data for csr_addr (slave -> master)
// ---------------------------------------------------------------------------
interface intr_csr_if;
  logic        csr_WE;
  logic [11:0] csr_addr;
  logic [31:0] csr_wd;
  logic [31:0] csr_rd;

  modport master (output csr_WE, output csr_addr, output csr_wd, input csr_rd);
  modport slave  (input csr_WE, input csr_addr, input csr_wd, output csr_rd);
endinterface

// File: rtl/intr_csr.sv
// ---------------------------------------------------------------------------
// intr_csr -- machine-mode interrupt CSRs with external interrupt capture.
//
// Holds mstatus (MIE/MPIE only), mtvec, mepc, mcause and a pending flag fed by
// a synchronized rising-edge detector on ext_intr.  mip is read-only and shows
// the pending flag in bit 11.
//
// Parameters
//   SYNC_STAGES  synchronizer depth on ext_intr (2..4)
//   MTVEC_RST    mtvec value after reset
//
// Ports
//   CSR_clk    sole clock, rising edge
//   CSR_RST    synchronous active-high reset
//   ext_intr   raw asynchronous external interrupt request
//   int_taken  control FSM is in its interrupt state (one cycle)
//   mret_exec  an mret executes this cycle
//   pc         PC register; resume address during int_taken
//   csr        CSR read/write bus (slave side)
//   mtvec      trap vector to the PC mux
//   mepc       return address to the PC mux
//   intr_req   pending AND mstatus.MIE, from registers only
// ---------------------------------------------------------------------------
module intr_csr #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] MTVEC_RST   = 32'h0000_0000
) (
  input  logic              CSR_clk,
  input  logic              CSR_RST,
  input  logic              ext_intr,
  input  logic              int_taken,
  input  logic              mret_exec,
  input  logic [31:0]       pc,
  intr_csr_if.slave         csr,
  output logic [31:0]       mtvec,
  output logic [31:0]       mepc,
  output logic              intr_req
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam logic [31:0] MCAUSE_EXT_INTR = 32'h8000_000B;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_prev;
  logic                   r_edge;
  logic                   r_pending;
  logic                   r_mie;
  logic                   r_mpie;
  logic [31:0]            r_mtvec;
  logic [31:0]            r_mepc;
  logic [31:0]            r_mcause;

  logic [31:0]            w_mstatus;
  logic [31:0]            w_mip;
  logic                   w_unused;

  // pc is word aligned on capture; its low bits never reach state.
  assign w_unused = ^pc[1:0];

  assign w_mstatus = {24'b0, r_mpie, 3'b0, r_mie, 3'b0};
  assign w_mip     = {20'b0, r_pending, 11'b0};

  assign mtvec    = r_mtvec;
  assign mepc     = r_mepc;
  assign intr_req = r_pending & r_mie;

  // NOTE: every register below updates with <= so all of them sample the
  // values from before this edge; blocking assignments here would let the
  // synchronizer collapse into a single stage and make results order-dependent.
  always_ff @(posedge CSR_clk) begin
    if (CSR_RST) begin
      r_sync      <= '0;
      r_sync_prev <= 1'b0;
      r_edge      <= 1'b0;
      r_pending   <= 1'b0;
      r_mie       <= 1'b0;
      r_mpie      <= 1'b0;
      r_mtvec     <= MTVEC_RST;
      r_mepc      <= '0;
      r_mcause    <= '0;
    end else begin
      // Synchronizer, then a registered rising-edge pulse.
      r_sync      <= {r_sync[SYNC_STAGES-2:0], ext_intr};
      r_sync_prev <= r_sync[SYNC_STAGES-1];
      r_edge      <= r_sync[SYNC_STAGES-1] & ~r_sync_prev;

      // A fresh edge wins over the clear so a request arriving while the
      // previous one is being taken is not dropped.
      if (r_edge)         r_pending <= 1'b1;
      else if (int_taken) r_pending <= 1'b0;

      // Only one CSR update source acts per cycle, highest priority first.
      if (int_taken) begin
        r_mepc   <= {pc[31:2], 2'b00};
        r_mcause <= MCAUSE_EXT_INTR;
        r_mpie   <= r_mie;
        r_mie    <= 1'b0;
      end else if (mret_exec) begin
        r_mie    <= r_mpie;
        r_mpie   <= 1'b1;
      end else if (csr.csr_WE) begin
        case (csr.csr_addr)
          ADDR_MSTATUS: begin
            r_mie  <= csr.csr_wd[3];
            r_mpie <= csr.csr_wd[7];
          end
          ADDR_MTVEC:  r_mtvec  <= {csr.csr_wd[31:2], 2'b00};
          ADDR_MEPC:   r_mepc   <= {csr.csr_wd[31:2], 2'b00};
          ADDR_MCAUSE: r_mcause <= csr.csr_wd;
          default: ;
        endcase
      end
    end
  end

  // NOTE: csr_rd gets a default before the case so every path assigns it and
  // no latch is inferred for unlisted addresses.
  always_comb begin
    csr.csr_rd = 32'h0;
    case (csr.csr_addr)
      ADDR_MSTATUS: csr.csr_rd = w_mstatus;
      ADDR_MTVEC:   csr.csr_rd = r_mtvec;
      ADDR_MEPC:    csr.csr_rd = r_mepc;
      ADDR_MCAUSE:  csr.csr_rd = r_mcause;
      ADDR_MIP:     csr.csr_rd = w_mip;
      default:      csr.csr_rd = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_intr_csr.sv
// ---------------------------------------------------------------------------
// tb_intr_csr -- directed self-checking bench for intr_csr.
// Inputs change 1 time unit after a rising edge; outputs are checked there,
// away from the active edge.
// ---------------------------------------------------------------------------
module tb_intr_csr;

  localparam int          S        = 2;
  localparam logic [31:0] MTVEC_RV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        ext_intr;
  logic        int_taken;
  logic        mret_exec;
  logic [31:0] pc;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        intr_req;

  int total = 0;
  int bad   = 0;

  intr_csr_if bus ();

  intr_csr #(
    .SYNC_STAGES (S),
    .MTVEC_RST   (MTVEC_RV)
  ) dut (
    .CSR_clk   (clk),
    .CSR_RST   (rst),
    .ext_intr  (ext_intr),
    .int_taken (int_taken),
    .mret_exec (mret_exec),
    .pc        (pc),
    .csr       (bus.slave),
    .mtvec     (mtvec),
    .mepc      (mepc),
    .intr_req  (intr_req)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    bus.csr_addr = a;
    #1;
    d = bus.csr_rd;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.csr_WE   = 1'b1;
    bus.csr_addr = a;
    bus.csr_wd   = d;
    tick();
    bus.csr_WE   = 1'b0;
  endtask

  logic [31:0] v;

  initial begin
    // Reset with competing updates asserted; reset must win.
    rst          = 1'b1;
    ext_intr     = 1'b0;
    int_taken    = 1'b1;
    mret_exec    = 1'b1;
    pc           = 32'h0000_0040;
    bus.csr_WE   = 1'b1;
    bus.csr_addr = 12'h305;
    bus.csr_wd   = 32'hFFFF_FFFF;
    tick();
    tick();
    rst = 1'b0; int_taken = 1'b0; mret_exec = 1'b0; bus.csr_WE = 1'b0;
    #1;
    check("rst_intr_req", {31'b0, intr_req}, 32'h0);
    check("rst_mtvec_port", mtvec, MTVEC_RV);
    check("rst_mepc_port", mepc, 32'h0);
    rd(12'h300, v); check("rst_mstatus", v, 32'h0);
    rd(12'h305, v); check("rst_mtvec", v, MTVEC_RV);
    rd(12'h342, v); check("rst_mcause", v, 32'h0);
    rd(12'h344, v); check("rst_mip", v, 32'h0);

    // Enable MIE; csr_rd shows the pre-write value during the write cycle.
    bus.csr_WE = 1'b1; bus.csr_addr = 12'h300; bus.csr_wd = 32'h0000_0008;
    #1;
    check("mstatus_prewrite", bus.csr_rd, 32'h0);
    tick();
    bus.csr_WE = 1'b0;
    rd(12'h300, v); check("mstatus_mie", v, 32'h0000_0008);

    // Edge latency: intr_req rises exactly S+2 edges after first sampled high.
    ext_intr = 1'b1;
    for (int n = 1; n <= S + 2; n++) begin
      tick();
      check($sformatf("latency_e%0d", n), {31'b0, intr_req}, (n == S + 2) ? 32'h1 : 32'h0);
    end
    rd(12'h344, v); check("mip_pending", v, 32'h0000_0800);

    // Take the interrupt; a same-cycle csr_WE to mepc is discarded.
    pc = 32'h0000_0127; int_taken = 1'b1;
    bus.csr_WE = 1'b1; bus.csr_addr = 12'h341; bus.csr_wd = 32'hDEAD_BEE0;
    tick();
    int_taken = 1'b0; bus.csr_WE = 1'b0;
    check("take_mepc", mepc, 32'h0000_0124);
    rd(12'h342, v); check("take_mcause", v, 32'h8000_000B);
    rd(12'h300, v); check("take_mstatus", v, 32'h0000_0080);
    check("take_intr_req", {31'b0, intr_req}, 32'h0);
    rd(12'h344, v); check("take_mip", v, 32'h0);
    // A held-high level must not re-pend.
    tick(); tick(); tick();
    rd(12'h344, v); check("level_no_repend", v, 32'h0);

    // mret restores MIE; a same-cycle mstatus write is discarded.
    mret_exec = 1'b1;
    bus.csr_WE = 1'b1; bus.csr_addr = 12'h300; bus.csr_wd = 32'h0;
    tick();
    mret_exec = 1'b0; bus.csr_WE = 1'b0;
    rd(12'h300, v); check("mret_mstatus", v, 32'h0000_0088);
    check("mret_no_req", {31'b0, intr_req}, 32'h0);

    // New edge after mret raises intr_req again.
    ext_intr = 1'b0;
    for (int n = 0; n < S + 2; n++) tick();
    ext_intr = 1'b1;
    for (int n = 0; n < S + 1; n++) tick();
    check("edge2_early", {31'b0, intr_req}, 32'h0);
    tick();
    check("edge2_req", {31'b0, intr_req}, 32'h1);

    // Edge pulse coincides with int_taken: pending must survive.
    ext_intr = 1'b0;
    for (int n = 0; n < S + 2; n++) tick();
    ext_intr = 1'b1;
    for (int n = 0; n < S + 1; n++) tick();
    pc = 32'h0000_0200; int_taken = 1'b1;
    tick();
    int_taken = 1'b0;
    rd(12'h344, v); check("coinc_mip", v, 32'h0000_0800);
    check("coinc_req_masked", {31'b0, intr_req}, 32'h0);
    check("coinc_mepc", mepc, 32'h0000_0200);
    mret_exec = 1'b1;
    tick();
    mret_exec = 1'b0;
    check("back_to_back_req", {31'b0, intr_req}, 32'h1);

    // Clear pending (level still high, no new edge), then write masking.
    int_taken = 1'b1;
    tick();
    int_taken = 1'b0;
    wr(12'h305, 32'hFFFF_FFFF);
    rd(12'h305, v); check("wr_mtvec", v, 32'hFFFF_FFFC);
    check("wr_mtvec_port", mtvec, 32'hFFFF_FFFC);
    wr(12'h341, 32'hFFFF_FFFF);
    rd(12'h341, v); check("wr_mepc", v, 32'hFFFF_FFFC);
    wr(12'h300, 32'hFFFF_FFFF);
    rd(12'h300, v); check("wr_mstatus", v, 32'h0000_0088);
    check("wr_no_req", {31'b0, intr_req}, 32'h0);
    wr(12'h344, 32'hFFFF_FFFF);
    rd(12'h344, v); check("wr_mip_ro", v, 32'h0);
    wr(12'h7C0, 32'hFFFF_FFFF);
    rd(12'h7C0, v); check("wr_unimpl", v, 32'h0);
    rd(12'h342, v); check("mcause_kept", v, 32'h8000_000B);
    wr(12'h342, 32'h1234_5679);
    rd(12'h342, v); check("wr_mcause", v, 32'h1234_5679);

    // Reset together with int_taken/mret/WE; an edge in flight is lost.
    ext_intr = 1'b0;
    for (int n = 0; n < S + 2; n++) tick();
    ext_intr = 1'b1;
    tick();
    rst = 1'b1; ext_intr = 1'b0; int_taken = 1'b1; mret_exec = 1'b1; pc = 32'h0000_0300;
    bus.csr_WE = 1'b1; bus.csr_addr = 12'h342; bus.csr_wd = 32'h5;
    tick();
    tick();
    rst = 1'b0; int_taken = 1'b0; mret_exec = 1'b0; bus.csr_WE = 1'b0;
    for (int n = 0; n < S + 3; n++) tick();
    rd(12'h344, v); check("rst2_mip_lost", v, 32'h0);
    check("rst2_intr_req", {31'b0, intr_req}, 32'h0);
    check("rst2_mtvec", mtvec, MTVEC_RV);
    check("rst2_mepc", mepc, 32'h0);
    rd(12'h342, v); check("rst2_mcause", v, 32'h0);
    rd(12'h300, v); check("rst2_mstatus", v, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/intr_csr.md
INTR_CSR -- requirements
Module: intr_csr

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flip-flop count of the ext_intr synchronizer; legal range 2..4.
REQ-002 Parameter MTVEC_RST, default 32'h0000_0000: mtvec value after reset.
REQ-003 CSR_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 CSR_RST  input  1  reset; one clock; synchronous and active-high.
REQ-005 ext_intr  input  1  raw asynchronous external interrupt request.
REQ-006 int_taken  input  1  from control FSM; high for the one cycle the FSM is in its interrupt state.
REQ-007 mret_exec  input  1  from control FSM; high for the one cycle an mret executes.
REQ-008 csr_WE  input  1  CSR write strobe from control FSM.
REQ-009 csr_addr  input  12  CSR address, from instruction bits [31:20].
REQ-010 csr_wd  input  32  CSR write data (final value, already merged for rw/rs/rc).
REQ-011 pc  input  32  PC register value; during int_taken it is the resume address.
REQ-012 csr_rd  output  32  read data for csr_addr.
REQ-013 mtvec  output  32  trap vector, to the PC mux.
REQ-014 mepc  output  32  return address, to the PC mux.
REQ-015 intr_req  output  1  interrupt request, to the control FSM interrupt input.

Function
REQ-016 Implemented CSRs: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342, mip 0x344 (read-only).
REQ-017 ext_intr passes through a SYNC_STAGES-deep synchronizer, then a rising-edge detector; each 0->1 transition of the synchronized signal yields a one-cycle edge pulse.
REQ-018 An edge pulse sets the pending flag; a level held high produces no further pulses.
REQ-019 int_taken clears pending; if an edge pulse occurs in the same cycle, pending stays 1.
REQ-020 intr_req = pending AND mstatus.MIE (bit 3); combinational from registers only, with no input-to-output path.
REQ-021 In an int_taken cycle: mepc <= {pc[31:2],2'b00}; mcause <= 32'h8000_000B; MPIE (bit 7) <= MIE; MIE <= 0.
REQ-022 In a mret_exec cycle: MIE <= MPIE; MPIE <= 1.
REQ-023 In a csr_WE cycle, write csr_wd to the CSR selected by csr_addr.
REQ-024 Update priority: CSR_RST > int_taken > mret_exec > csr_WE; the lower-priority CSR update is discarded.
REQ-025 mstatus writes affect only bits 3 and 7; all other mstatus bits read 0.
REQ-026 mtvec and mepc writes force bits [1:0] to 0.
REQ-027 mcause accepts all 32 bits.
REQ-028 mip reads {20'b0, pending, 11'b0}; writes to mip are ignored.
REQ-029 Writes to an unimplemented address have no effect; reads from one return 32'h0.
REQ-030 csr_rd is combinational on csr_addr and current register values; in a write cycle it shows the pre-write value.
REQ-031 The mtvec and mepc outputs equal the register contents at all times; a new value is visible the cycle after the update.
REQ-032 Back-to-back interrupts are possible: after an mret restores MIE=1, a still-set pending raises intr_req in the next cycle.

Reset
REQ-033 When CSR_RST=1 at a clock edge: mstatus, mepc, mcause, pending and synchronizer/edge registers <= 0; mtvec <= MTVEC_RST.
REQ-034 After reset: intr_req=0; csr_rd reflects the reset values.
REQ-035 CSR_RST overrides int_taken, mret_exec and csr_WE asserted in the same cycle.
REQ-036 An ext_intr edge in flight in the synchronizer during reset is lost.

Verification
REQ-037 Reset, write mstatus=0x8 via csr_WE, pulse ext_intr 0->1 -> intr_req=1 exactly SYNC_STAGES+2 cycles after the first sampled high; mip reads 0x800.
REQ-038 intr_req=1, pc=0x0000_0124, assert int_taken -> next cycle mepc=0x124, mcause=0x8000_000B, mstatus=0x80, intr_req=0, pending=0.
REQ-039 From REQ-038 state, assert mret_exec -> mstatus=0x88; a new ext_intr edge -> intr_req=1.
REQ-040 Same-cycle int_taken and edge pulse -> pending remains 1 and intr_req reasserts immediately after mret.
REQ-041 csr_WE with csr_wd=0xFFFF_FFFF to mtvec, mepc, mstatus, mip and addr 0x7C0 -> reads 0xFFFF_FFFC, 0xFFFF_FFFC, 0x88, 0x0 (pending=0), 0x0.
REQ-042 CSR_RST asserted together with int_taken -> all CSRs at reset values; mepc unchanged from 0.
